uart_cmd_decoder: RTL
=====================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 25000: max clock cycles between bytes inside a frame (about 2 byte times at 9600 baud).
REQ-003 SHALL have port clock, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous active-low reset.
REQ-005 SHALL have port rx_value, input, 8: received byte from UART receiver.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe, rx_value valid.
REQ-007 SHALL have port cmd_valid, output, 1: decoded command available.
REQ-008 SHALL have port cmd_ready, input, 1: ALU side accepts command.
REQ-009 SHALL have port cmd_op, output, 4: ALU opcode.
REQ-010 SHALL have port cmd_a, output, 8: operand A.
REQ-011 SHALL have port cmd_b, output, 8: operand B.
REQ-012 SHALL have port frame_err, output, 1: one-cycle error strobe.
REQ-013 SHALL have port err_code, output, 2: 00 overrun, 01 timeout, 10 bad opcode, 11 checksum; meaningful only while frame_err=1.

Function
REQ-014 SHALL accept the frame SYNC_BYTE, OPC, A, B, plus CHK when CHECKSUM_EN is defined, one byte per rx_valid strobe.
REQ-015 SHALL use states IDLE, GET_OP, GET_A, GET_B and CHK (CHK only when CHECKSUM_EN is defined); each state advances on rx_valid.
REQ-016 In IDLE, SHALL move to GET_OP on rx_valid with rx_value==SYNC_BYTE and silently ignore all other bytes.
REQ-017 In GET_OP, SHALL treat OPC[7:4]!=0 as a bad opcode: return to IDLE and pulse frame_err with err_code=10 in the next cycle.
REQ-018 When the final frame byte is received on rx_valid in cycle N, SHALL present cmd_valid=1 with cmd_op/cmd_a/cmd_b in cycle N+1, and return to IDLE.
REQ-019 SHALL hold cmd_valid and cmd_op/cmd_a/cmd_b stable until a cycle with cmd_valid and cmd_ready both high; cmd_valid SHALL drop the following cycle unless REQ-021 applies.
REQ-020 If a frame completes while cmd_valid=1 and the command is not accepted in that cycle, SHALL discard the new frame, keep the old command, and pulse frame_err with err_code=00.
REQ-021 If a frame completes in the same cycle the pending command is accepted, SHALL load the new command and keep cmd_valid=1.
REQ-022 Timeout counter SHALL be active only outside IDLE, SHALL clear on every rx_valid, and on reaching TIMEOUT_CYC-1 SHALL return the FSM to IDLE and pulse frame_err with err_code=01.
REQ-023 If rx_valid and timeout expiry coincide, the byte SHALL win and no error SHALL be raised.
REQ-024 SHALL assert frame_err for exactly one cycle per error; at most one error per cycle, with priority overrun > checksum > opcode > timeout.
REQ-025 A SYNC_BYTE value received mid-frame SHALL be treated as data, not as a resync.

Reset
REQ-026 While reset=0 at a clock edge, SHALL force state IDLE, timeout counter 0, and cmd_valid, cmd_op, cmd_a, cmd_b, frame_err, err_code to 0.
REQ-027 Reset mid-frame or with a pending command SHALL discard both with no error strobe.

Configuration
REQ-028 Macro UART_CMD_CHECKSUM_EN SHALL control the checksum feature.
REQ-029 With UART_CMD_CHECKSUM_EN defined, SHALL require CHK==OPC^A^B; on mismatch, SHALL issue no command and SHALL pulse frame_err with err_code=11.
REQ-030 Without UART_CMD_CHECKSUM_EN, SHALL use 4-byte frames with no CHK state and SHALL never produce err_code=11.

Structure
REQ-031 Shared package alu_uart_pkg SHALL hold the FSM state encoding, the err_code constants, the SYNC_BYTE default and the opcode width (4).
REQ-032 SHALL place the timeout logic in sub-module frame_timeout_cnt, with inputs clock, reset, en, clr and output expired.

Verification
REQ-033 Bytes A5,03,12,34 with cmd_ready=1 -> cmd_valid for 1 cycle one cycle after the last strobe, with op=3, a=12, b=34.
REQ-034 Bytes 00,A5,25,.. -> the 00 is ignored; frame_err=1 with err_code=10 and no cmd_valid.
REQ-035 Bytes A5,01 followed by a gap of TIMEOUT_CYC cycles -> frame_err with err_code=01, FSM in IDLE; a following A5,02,05,06 decodes normally.
REQ-036 Two complete frames with cmd_ready=0 -> the first command is held and the second completion gives frame_err with err_code=00; raising cmd_ready -> first command accepted, cmd_valid drops.
REQ-037 With UART_CMD_CHECKSUM_EN: A5,04,0F,F0,FB decodes; A5,04,0F,F0,00 gives frame_err with err_code=11.
REQ-038 reset=0 asserted after A5,01 -> all outputs 0 and no error; a new frame afterwards decodes correctly.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the UART command decoder.
// Frame states, error codes, sync default and opcode width.
package alu_uart_pkg;

    localparam int OP_W = 4;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_OP,
        S_GET_A,
        S_GET_B,
        S_CHK
    } state_t;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BADOP   = 2'b10;
    localparam logic [1:0] ERR_CHKSUM  = 2'b11;

    function automatic logic [7:0] frame_chk(
        input logic [OP_W-1:0] op,
        input logic [7:0]      a,
        input logic [7:0]      b
    );
        return {{(8-OP_W){1'b0}}, op} ^ a ^ b;
    endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte gap counter; expired is high while the gap reaches
// TIMEOUT_CYC-1 cycles with the counter enabled.
module frame_timeout_cnt #(
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] r_cnt;

    // Saturate at the limit; the FSM leaves the frame on expiry anyway.
    always_ff @(posedge clock) begin
        if (!reset || !en || clr) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = en && (r_cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Byte-stream frame decoder: SYNC, OPC, A, B (+CHK) to an ALU command.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_cmd_decoder
    import alu_uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int          TIMEOUT_CYC = 25000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      rx_value,
    input  logic            rx_valid,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [OP_W-1:0] cmd_op,
    output logic [7:0]      cmd_a,
    output logic [7:0]      cmd_b,
    output logic            frame_err,
    output logic [1:0]      err_code
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OP_W-1:0] r_op;
    logic [7:0]      r_a;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]      r_b;
`endif

    logic            w_expired;
    logic            w_done;
    logic            w_fail;
    logic [1:0]      w_fail_code;
    logic [7:0]      w_fin_b;
    logic            w_overrun;
    logic            w_accept;

    frame_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .en     (r_state != S_IDLE),
        .clr    (rx_valid),
        .expired(w_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = ERR_OVERRUN;
        w_fin_b     = rx_value;
        unique case (r_state)
            S_IDLE: begin
                if (rx_valid && rx_value == SYNC_BYTE) begin
                    w_state_nxt = S_GET_OP;
                end
            end
            S_GET_OP: begin
                if (rx_valid) begin
                    if (rx_value[7:OP_W] != '0) begin
                        w_state_nxt = S_IDLE;
                        w_fail      = 1'b1;
                        w_fail_code = ERR_BADOP;
                    end else begin
                        w_state_nxt = S_GET_A;
                    end
                end
            end
            S_GET_A: begin
                if (rx_valid) begin
                    w_state_nxt = S_GET_B;
                end
            end
            S_GET_B: begin
                if (rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
                    w_state_nxt = S_CHK;
`else
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CHK: begin
                w_fin_b = r_b;
                if (rx_valid) begin
                    w_state_nxt = S_IDLE;
                    if (rx_value == frame_chk(r_op, r_a, r_b)) begin
                        w_done = 1'b1;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_CHKSUM;
                    end
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        // A byte arriving on the expiry cycle wins over the timeout.
        if (r_state != S_IDLE && !rx_valid && w_expired) begin
            w_state_nxt = S_IDLE;
            w_fail      = 1'b1;
            w_fail_code = ERR_TIMEOUT;
        end
    end

    assign w_accept  = cmd_valid && cmd_ready;
    assign w_overrun = w_done && cmd_valid && !cmd_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_op      <= '0;
            r_a       <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            r_b       <= '0;
`endif
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_a     <= '0;
            cmd_b     <= '0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            frame_err <= w_fail || w_overrun;
            err_code  <= w_overrun ? ERR_OVERRUN :
                         (w_fail ? w_fail_code : 2'b00);
            if (rx_valid && r_state == S_GET_OP) r_op <= rx_value[OP_W-1:0];
            if (rx_valid && r_state == S_GET_A)  r_a  <= rx_value;
`ifdef UART_CMD_CHECKSUM_EN
            if (rx_valid && r_state == S_GET_B)  r_b  <= rx_value;
`endif
            if (w_done && !w_overrun) begin
                cmd_valid <= 1'b1;
                cmd_op    <= r_op;
                cmd_a     <= r_a;
                cmd_b     <= w_fin_b;
            end else if (w_accept) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule
